// File: rtl/cdc_fifo_src_arbiter.sv
// Round-robin arbiter feeding one CDC FIFO source port through a single output register.
// Define CDC_FIFO_ARB_LOCK_EN to hold the grant for a whole burst (until req_last_i).
module cdc_fifo_src_arbiter #(
  parameter int NumIn     = 4,
  parameter int DataWidth = 32,
  parameter int IdWidth   = $clog2(NumIn)
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [NumIn-1:0]           req_valid_i,
  output logic [NumIn-1:0]           req_ready_o,
  input  logic [NumIn*DataWidth-1:0] req_data_i,
  input  logic [NumIn-1:0]           req_last_i,
  output logic                       fifo_valid_o,
  input  logic                       fifo_ready_i,
  output logic [DataWidth-1:0]       fifo_data_o,
  output logic [IdWidth-1:0]         fifo_id_o,
  output logic                       fifo_last_o,
  output logic                       locked_o
);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_e;

  state_e                 state_q, state_d;
  logic [IdWidth-1:0]     rr_q, rr_d;
  logic                   fvalid_q, fvalid_d;
  logic [DataWidth-1:0]   data_q, data_d;
  logic [IdWidth-1:0]     id_q, id_d;
  logic                   last_q, last_d;

  logic [DataWidth-1:0]   data_arr [NumIn];
  logic [IdWidth-1:0]     cand, rr_gnt, gnt, gnt_next;
  logic                   reg_free, gnt_valid, gnt_last, accept;

  for (genvar i = 0; i < NumIn; i++) begin : g_unpack
    assign data_arr[i] = req_data_i[i*DataWidth +: DataWidth];
  end

  // Lowest offset from rr_q wins, so scan offsets from the top down.
  always_comb begin
    rr_gnt = rr_q;
    cand   = rr_q;
    for (int k = NumIn - 1; k >= 0; k--) begin
      cand = IdWidth'((int'(rr_q) + k) % NumIn);
      if (req_valid_i[cand]) rr_gnt = cand;
    end
  end

`ifdef CDC_FIFO_ARB_LOCK_EN
  logic [IdWidth-1:0] lock_id_q, lock_id_d;
  assign gnt      = (state_q == ST_LOCKED) ? lock_id_q : rr_gnt;
  assign locked_o = (state_q == ST_LOCKED);
`else
  assign gnt      = rr_gnt;
  assign locked_o = 1'b0;
`endif

  // Reset gating keeps every ready low while rst_ni is held.
  assign reg_free    = rst_ni & (~fvalid_q | fifo_ready_i);
  assign gnt_valid   = req_valid_i[gnt];
  assign gnt_last    = req_last_i[gnt];
  assign accept      = reg_free & gnt_valid;
  assign gnt_next    = (gnt == IdWidth'(NumIn - 1)) ? '0 : gnt + 1'b1;
  assign req_ready_o = accept ? ({{(NumIn-1){1'b0}}, 1'b1} << gnt) : '0;

  always_comb begin
    fvalid_d = fvalid_q;
    data_d   = data_q;
    id_d     = id_q;
    last_d   = last_q;
    if (accept) begin
      fvalid_d = 1'b1;
      data_d   = data_arr[gnt];
      id_d     = gnt;
      last_d   = gnt_last;
    end else if (fifo_ready_i) begin
      fvalid_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
`ifdef CDC_FIFO_ARB_LOCK_EN
    lock_id_d = lock_id_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (gnt_last) begin
            rr_d = gnt_next;
          end else begin
            state_d   = ST_LOCKED;
            lock_id_d = gnt;
          end
        end
      end
      ST_LOCKED: begin
        if (accept && gnt_last) begin
          state_d = ST_IDLE;
          rr_d    = gnt_next;
        end
      end
      default: state_d = ST_IDLE;
    endcase
`else
    if (accept) rr_d = gnt_next;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      rr_q     <= '0;
      fvalid_q <= 1'b0;
      data_q   <= '0;
      id_q     <= '0;
      last_q   <= 1'b0;
`ifdef CDC_FIFO_ARB_LOCK_EN
      lock_id_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      fvalid_q <= fvalid_d;
      data_q   <= data_d;
      id_q     <= id_d;
      last_q   <= last_d;
`ifdef CDC_FIFO_ARB_LOCK_EN
      lock_id_q <= lock_id_d;
`endif
    end
  end

  assign fifo_valid_o = fvalid_q;
  assign fifo_data_o  = data_q;
  assign fifo_id_o    = id_q;
  assign fifo_last_o  = last_q;

endmodule

// File: tb/tb_cdc_fifo_src_arbiter.sv
// Self-checking bench for cdc_fifo_src_arbiter: vector table, directed corner sequences and
// randomized traffic against a queue-level reference model.
module tb_cdc_fifo_src_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 2;
`ifdef CDC_FIFO_ARB_LOCK_EN
  localparam bit LockEn = 1'b1;
`else
  localparam bit LockEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  valid, last, ready;
  logic [N*DW-1:0] data;
  logic          fready, fvalid, flast, locked;
  logic [DW-1:0] fdata;
  logic [IW-1:0] fid;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cdc_fifo_src_arbiter #(.NumIn(N), .DataWidth(DW), .IdWidth(IW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(valid), .req_ready_o(ready), .req_data_i(data), .req_last_i(last),
    .fifo_valid_o(fvalid), .fifo_ready_i(fready), .fifo_data_o(fdata),
    .fifo_id_o(fid), .fifo_last_o(flast), .locked_o(locked)
  );

  // Reference model: one held beat, a round-robin pointer and an optional burst owner.
  bit            m_valid, m_last, m_locked;
  logic [DW-1:0] m_data;
  int            m_id, m_rr, m_lid;

  function automatic void model_reset();
    m_valid = 0; m_last = 0; m_locked = 0; m_data = '0;
    m_id = 0; m_rr = 0; m_lid = 0;
  endfunction

  function automatic int model_grant();
    if (m_locked) return valid[m_lid] ? m_lid : -1;
    for (int k = 0; k < N; k++)
      if (valid[(m_rr + k) % N]) return (m_rr + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] one = 1;
    int g = model_grant();
    if ((!m_valid || fready) && g >= 0) return one << g;
    return '0;
  endfunction

  function automatic void model_edge();
    int g = model_grant();
    if ((!m_valid || fready) && g >= 0) begin
      m_valid = 1; m_data = data[g*DW +: DW]; m_id = g; m_last = last[g];
      if (!LockEn || last[g]) begin
        m_locked = 0;
        m_rr = (g + 1) % N;
      end else if (!m_locked) begin
        m_locked = 1;
        m_lid = g;
      end
    end else if (fready) begin
      m_valid = 0;
    end
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("model_ready", ready, model_ready());
    chk("model_fvalid", fvalid, m_valid);
    chk("model_locked", locked, m_locked);
    if (m_valid) begin
      chk("model_data", fdata, m_data);
      chk("model_id", fid, m_id);
      chk("model_last", flast, m_last);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_ready", ready, 0);
    chk("rst_fvalid", fvalid, 0);
    chk("rst_fdata", fdata, 0);
    chk("rst_fid", fid, 0);
    chk("rst_flast", flast, 0);
    chk("rst_locked", locked, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [N-1:0] valid, last;
    logic         fready;
    logic [N-1:0] exp_ready;
    logic         exp_fvalid;
    logic [IW-1:0] exp_id;
  } vec_t;
  vec_t tbl [11];

  initial begin
    int lock_ids [4];
    tbl[0]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0};
    tbl[1]  = '{4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0};
    tbl[2]  = '{4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1};
    tbl[3]  = '{4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd2};
    tbl[4]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd3};
    tbl[5]  = '{4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0};
    tbl[6]  = '{4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1};
    tbl[7]  = '{4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd1};
    tbl[8]  = '{4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1};
    tbl[9]  = '{4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b1, 2'd2};
    tbl[10] = '{4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b0, 2'd0};

    valid = '1; last = '1; fready = 1'b1;
    for (int i = 0; i < N; i++) data[i*DW +: DW] = 32'hD000_0000 + i;
    @(negedge clk);
    do_reset();

    // Fairness, backpressure and drain from the vector table.
    for (int i = 0; i < 11; i++) begin
      valid = tbl[i].valid; last = tbl[i].last; fready = tbl[i].fready;
      #1;
      chk($sformatf("tbl%0d_ready", i), ready, tbl[i].exp_ready);
      chk($sformatf("tbl%0d_fvalid", i), fvalid, tbl[i].exp_fvalid);
      if (tbl[i].exp_fvalid) chk($sformatf("tbl%0d_id", i), fid, tbl[i].exp_id);
      tick();
    end

    // Backpressure: held beat stays stable for 5 cycles, then drains with no bubble.
    do_reset();
    data[1*DW +: DW] = 32'hA5A5_A5A5;
    valid = 4'b0010; last = 4'b1111; fready = 1'b1;
    #1; chk("bp_accept_ready", ready, 4'b0010);
    tick();
    valid = 4'b1111; fready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_hold_valid", fvalid, 1);
      chk("bp_hold_data", fdata, 32'hA5A5_A5A5);
      chk("bp_hold_id", fid, 1);
      chk("bp_hold_ready", ready, 4'b0000);
      tick();
    end
    fready = 1'b1;
    #1; chk("bp_release_ready", ready, 4'b0100);
    tick();
    #1;
    chk("bp_next_valid", fvalid, 1);
    chk("bp_next_id", fid, 2);
    chk("bp_next_data", fdata, 32'hD000_0002);

`ifdef CDC_FIFO_ARB_LOCK_EN
    // Burst lock: point rr at 2 with a single beat from 1, then a 3-beat burst from 2.
    do_reset();
    valid = 4'b0010; last = 4'b0010; fready = 1'b1;
    tick();
    valid = 4'b0110;
    #1; chk("lk_first_ready", ready, 4'b0100); chk("lk_pre_locked", locked, 0);
    tick();
    #1; chk("lk_b1_id", fid, 2); chk("lk_b1_locked", locked, 1);
    valid = 4'b0010;
    #1; chk("lk_owner_idle_ready", ready, 4'b0000);
    tick();
    #1; chk("lk_gap_fvalid", fvalid, 0); chk("lk_gap_locked", locked, 1);
    valid = 4'b0110;
    tick();
    #1; chk("lk_b2_id", fid, 2); chk("lk_b2_locked", locked, 1);
    last = 4'b0110;
    tick();
    #1; chk("lk_b3_id", fid, 2); chk("lk_b3_last", flast, 1); chk("lk_b3_locked", locked, 0);
    tick();
    #1; chk("lk_after_id", fid, 1);
`else
    // Without lock, two requesters alternate per beat and last passes straight through.
    do_reset();
    lock_ids = '{1, 2, 1, 2};
    valid = 4'b0110; last = 4'b0010; fready = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("nolk_id%0d", i), fid, lock_ids[i]);
      chk($sformatf("nolk_last%0d", i), flast, lock_ids[i] == 1);
      chk($sformatf("nolk_locked%0d", i), locked, 0);
      tick();
    end
`endif

    // Pointer wrap after requester 3, then reset pulse mid-stall.
    do_reset();
    valid = 4'b1000; last = 4'b1111; fready = 1'b1;
    #1; chk("wrap_ready3", ready, 4'b1000);
    tick();
    valid = 4'b1111; fready = 1'b0;
    #1; chk("wrap_stall_id", fid, 3); chk("wrap_stall_ready", ready, 4'b0000);
    tick();
    rst_n = 1'b0;
    model_reset();
    #1; chk("wrap_rst_fvalid", fvalid, 0); chk("wrap_rst_ready", ready, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1; valid = 4'b0000;
    tick();
    #1; chk("wrap_no_ghost", fvalid, 0);
    valid = 4'b1111; fready = 1'b1;
    #1; chk("wrap_post_rst_ready", ready, 4'b0001);
    tick();
    #1; chk("wrap_post_rst_id", fid, 0);

    // Randomized traffic against the reference model.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      valid  = N'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) last[i] = ($urandom_range(0, 2) == 0);
      fready = ($urandom_range(0, 2) != 0);
      for (int i = 0; i < N; i++) data[i*DW +: DW] = $urandom;
      #1;
      check_model();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
